// File: rtl/if_fetch_ctrl.sv
// Purpose: fetch-stage sequencer; owns the PC, reads a combinational imem, buffers {pc, instr} for decode.
// Latency: one cycle from fetch to id_valid_o; two cycles from a redirect pulse to the first new id_valid_o.
// Backpressure: id_ready_i low fills the FIFO, then fetch stalls with imem_addr_o held at pc_q.
//
// Ports:
//   clk_i, rst_ni          clock and async active-low reset
//   imem_addr_o/imem_rd_i  byte address to instruction memory, returned word (same cycle)
//   imem_rst_o             memory reset strobe, high while the sequencer is initialising
//   redirect_valid_i/_pc_i taken branch/jump target from EX (one-cycle pulse)
//   id_valid_o/id_ready_i  valid/ready handshake toward decode; id_pc_o/id_instr_o carry the head
//   fault_o                sticky illegal-redirect flag, cleared by a legal redirect
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rd_i,
  output logic        imem_rst_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic        fault_o
);

  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(BUF_DEPTH);
  localparam logic [31:0]   WORDS_C   = 32'(IMEM_WORDS);
  localparam logic [31:0]   LAST_WORD = 32'(IMEM_WORDS - 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic          fault_q, fault_d;
  logic [31:0]   last_pc_q, last_instr_q;
  logic [31:0]   pc_mem_q    [BUF_DEPTH];
  logic [31:0]   instr_mem_q [BUF_DEPTH];

  logic          deq, enq, redir, redir_legal;
  logic [31:0]   pc_next;

  assign id_valid_o  = (state_q == S_RUN) && (count_q != '0);
  assign deq         = id_valid_o && id_ready_i;
  assign redir       = redirect_valid_i && (state_q != S_INIT);
  assign redir_legal = (redirect_pc_i[1:0] == 2'b00) && ({2'b00, redirect_pc_i[31:2]} < WORDS_C);
  // A full FIFO may still accept when the head leaves in the same cycle.
  assign enq         = (state_q == S_RUN) && !redir && ((count_q < DEPTH_C) || deq);
  // Word index wraps modulo the memory depth rather than running off the end.
  assign pc_next     = ({2'b00, pc_q[31:2]} == LAST_WORD) ? 32'h0 : pc_q + 32'd4;

  assign imem_addr_o = pc_q;
  assign imem_rst_o  = (state_q == S_INIT);
  assign fault_o     = fault_q;
  // With nothing to present, the last shown pair stays on the bus instead of stale slot data.
  assign id_pc_o     = id_valid_o ? pc_mem_q[rd_ptr_q]    : last_pc_q;
  assign id_instr_o  = id_valid_o ? instr_mem_q[rd_ptr_q] : last_instr_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fault_d  = fault_q;
    case (state_q)
      S_INIT: state_d = S_RUN;
      S_RUN, S_FAULT: begin
        if (redir) begin
          // Any handshake this cycle still completes; everything behind it is dropped.
          count_d  = '0;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          if (redir_legal) begin
            pc_d    = redirect_pc_i;
            state_d = S_RUN;
            fault_d = 1'b0;
          end else begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end
        end else begin
          if (enq) begin
            pc_d     = pc_next;
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
          if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
          case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
          endcase
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_INIT;
      pc_q         <= RESET_PC;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fault_q      <= 1'b0;
      last_pc_q    <= 32'h0;
      last_instr_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fault_q  <= fault_d;
      if (id_valid_o) begin
        last_pc_q    <= pc_mem_q[rd_ptr_q];
        last_instr_q <= instr_mem_q[rd_ptr_q];
      end
    end
  end

  // Storage needs no reset: it is only visible through id_valid_o.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rd_i;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed vector table, corner sequences, randomized run against a queue model.
module tb_if_fetch_ctrl;

  localparam int unsigned WORDS = 1024;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_rd, redirect_pc, id_pc, id_instr;
  logic        imem_rst, redirect_valid, id_valid, id_ready, fault;

  logic [31:0] mem [WORDS];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_mode;   // 0 = initialising, 1 = running, 2 = faulted
  logic [31:0] m_pc;
  logic [63:0] m_q [$];
  logic        m_fault;
  logic [31:0] m_last_pc, m_last_instr;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        imst;
  } vec_t;
  vec_t tbl [21];

  if_fetch_ctrl #(
    .RESET_PC  (32'h0),
    .IMEM_WORDS(WORDS),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .imem_addr_o     (imem_addr),
    .imem_rd_i       (imem_rd),
    .imem_rst_o      (imem_rst),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .id_valid_o      (id_valid),
    .id_ready_i      (id_ready),
    .id_pc_o         (id_pc),
    .id_instr_o      (id_instr),
    .fault_o         (fault)
  );

  always #5 clk = ~clk;

  assign imem_rd = imem_rst ? 32'h0 : mem[imem_addr[11:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 32'd4 == 32'd0) && (a / 32'd4 < 32'(WORDS));
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_pc = 32'h0;
    m_q.delete();
    m_fault = 1'b0;
    m_last_pc = 32'h0;
    m_last_instr = 32'h0;
  endtask

  task automatic check_model();
    logic        v;
    logic [63:0] h;
    v = (m_mode == 1) && (m_q.size() > 0);
    h = v ? m_q[0] : {m_last_pc, m_last_instr};
    chk("id_valid", 32'(id_valid), 32'(v));
    chk("id_pc", id_pc, h[63:32]);
    chk("id_instr", id_instr, h[31:0]);
    chk("imem_addr", imem_addr, m_pc);
    chk("imem_rst", 32'(imem_rst), 32'(m_mode == 0));
    chk("fault", 32'(fault), 32'(m_fault));
  endtask

  // One clock of the spec's rules, expressed on a queue of {pc, instr}.
  task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
    bit v;
    v = (m_mode == 1) && (m_q.size() > 0);
    if (v) {m_last_pc, m_last_instr} = m_q[0];
    if (v && rdy) void'(m_q.pop_front());
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (rv) begin
      m_q.delete();
      if (legal(rpc)) begin
        m_pc = rpc;
        m_mode = 1;
        m_fault = 1'b0;
      end else begin
        m_mode = 2;
        m_fault = 1'b1;
      end
    end else if (m_mode == 1 && m_q.size() < DEPTH) begin
      m_q.push_back({m_pc, mem[m_pc / 32'd4]});
      m_pc = ((m_pc / 32'd4 + 32'd1) % 32'(WORDS)) * 32'd4;
    end
  endtask

  task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy);
    check_model();
    redirect_valid = rv;
    redirect_pc = rpc;
    id_ready = rdy;
    model_step(rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] rpc;
    int          kind;

    for (int i = 0; i < int'(WORDS); i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0030_0113;
    mem[2] = 32'h0020_81B3;
    mem[7] = 32'h0020_F433;

    //            rst   rdy   v     pc      instr          addr    imst
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 32'h0,         32'h00, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h00, 32'h0,         32'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h00, 32'h0050_0093, 32'h04, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h04, 32'h0030_0113, 32'h08, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h08, 32'h0020_81B3, 32'h0C, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 32'hC0DE_0003, 32'h10, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 32'hC0DE_0003, 32'h14, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 32'hC0DE_0003, 32'h14, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'h10, 32'hC0DE_0004, 32'h18, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h14, 32'hC0DE_0005, 32'h1C, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h00, 32'h0,         32'h00, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h00, 32'h0,         32'h00, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 32'h00, 32'h0050_0093, 32'h04, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 32'h00, 32'h0050_0093, 32'h08, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 32'h00, 32'h0050_0093, 32'h08, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 32'h00, 32'h0050_0093, 32'h08, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 32'h00, 32'h0050_0093, 32'h08, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 32'h00, 32'h0050_0093, 32'h08, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 32'h04, 32'h0030_0113, 32'h0C, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 32'h08, 32'h0020_81B3, 32'h10, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b1, 32'h0C, 32'hC0DE_0003, 32'h14, 1'b0};

    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);

    // Directed table: reset release, streaming, stall with full FIFO, reset mid-stream.
    for (int i = 0; i < 21; i++) begin
      chk($sformatf("tbl%0d_valid", i), 32'(id_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_pc", i), id_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_instr", i), id_instr, tbl[i].instr);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_imst", i), 32'(imem_rst), 32'(tbl[i].imst));
      chk($sformatf("tbl%0d_fault", i), 32'(fault), 32'h0);
      rst_n = tbl[i].rst_n;
      id_ready = tbl[i].rdy;
      @(posedge clk);
      @(negedge clk);
    end

    // Redirect to 0x1C with two entries buffered.
    do_reset();
    repeat (3) cyc(1'b0, 32'h0, 1'b0);
    chk("t3_full_head", id_pc, 32'h0);
    cyc(1'b1, 32'h1C, 1'b0);
    chk("t3_gap_valid", 32'(id_valid), 32'h0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t3_new_valid", 32'(id_valid), 32'h1);
    chk("t3_new_pc", id_pc, 32'h1C);
    chk("t3_new_instr", id_instr, 32'h0020_F433);

    // Illegal targets, then recovery.
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h1E, 1'b1);
    chk("t4_fault_set", 32'(fault), 32'h1);
    chk("t4_valid_low", 32'(id_valid), 32'h0);
    cyc(1'b1, 32'h1000, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    chk("t4_fault_held", 32'(fault), 32'h1);
    chk("t4_addr_frozen", imem_addr, 32'h2C);
    cyc(1'b1, 32'h4, 1'b1);
    chk("t4_fault_clear", 32'(fault), 32'h0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t4_resume_pc", id_pc, 32'h4);

    // PC wrap at the top of memory.
    cyc(1'b1, 32'hFF8, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    chk("t5_wrap_pc", id_pc, 32'h0);
    chk("t5_wrap_fault", 32'(fault), 32'h0);

    // Handshake and redirect together with a full FIFO.
    repeat (3) cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h40, 1'b1);
    chk("t6_flush_valid", 32'(id_valid), 32'h0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t6_next_pc", id_pc, 32'h40);

    // Asynchronous reset between clock edges.
    repeat (2) cyc(1'b0, 32'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(id_valid), 32'h0);
    chk("t6_rst_pc", id_pc, 32'h0);
    chk("t6_rst_instr", id_instr, 32'h0);
    chk("t6_rst_addr", imem_addr, 32'h0);
    chk("t6_rst_imst", 32'(imem_rst), 32'h1);
    chk("t6_rst_fault", 32'(fault), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the queue model.
    for (int n = 0; n < 2000; n++) begin
      kind = int'($urandom_range(0, 9));
      case (kind)
        0:       rpc = $urandom_range(0, WORDS - 1) * 4 + $urandom_range(1, 3);
        1:       rpc = $urandom_range(WORDS, 4 * WORDS) * 4;
        2:       rpc = (WORDS - 1 - $urandom_range(0, 3)) * 4;
        default: rpc = $urandom_range(0, WORDS - 1) * 4;
      endcase
      cyc(($urandom_range(0, 9) == 0), rpc, ($urandom_range(0, 3) != 0));
    end
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
